tsmp_pkt_arb: RTL and testbench

- Packet-granular round-robin arbiter that shares the single 9-bit framed stream input of the TSMP packet filter among N_PORTS sources.
- A grant is held from a source's head word through its tail word. A configurable idle gap is enforced between packets.
- A stalled source is aborted by a watchdog. If it stalls mid-packet, the arbiter injects a tail so the downstream frame parser re-synchronises.

---
 rtl/tsmp_pkt_arb.sv | 204 ++++++++++++++++++++
 tb/tb_tsmp_pkt_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsmp_pkt_arb.sv
// -----------------------------------------------------------------------------
// tsmp_pkt_arb
//   Packet-granular round-robin arbiter that merges N_PORTS framed 9-bit word
//   streams into the single input of the TSMP packet filter. A grant is held
//   from a source's head word to its tail word, followed by GAP_CYCLES forced
//   idle cycles. A watchdog aborts a stalled source. If the stall happens
//   mid-packet, a tail word {1, zeros} is injected so the downstream parser
//   resynchronises.
//
// Ports
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   iv_req       per-port request (level)
//   ov_grant     one-hot grant (registered)
//   iv_data      port p at [p*DATA_WIDTH +: DATA_WIDTH]; MSB is the frame flag
//   iv_data_wr   per-port word valid
//   ov_data      merged stream word (registered, holds when idle)
//   o_data_wr    merged stream valid
//   ov_cur_port  index of the last/current granted port
//   o_timeout    one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module tsmp_pkt_arb #(
    parameter int DATA_WIDTH = 9,
    parameter int N_PORTS    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [N_PORTS-1:0]              iv_req,
    output logic [N_PORTS-1:0]              ov_grant,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   iv_data,
    input  logic [N_PORTS-1:0]              iv_data_wr,
    output logic [DATA_WIDTH-1:0]           ov_data,
    output logic                            o_data_wr,
    output logic [2:0]                      ov_cur_port,
    output logic                            o_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_HEAD, XFER, GAP} state_t;

    localparam int          FLAG      = DATA_WIDTH - 1;
    // Abort fires on the TIMEOUT-th consecutive cycle without a granted write.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                 state, state_nx;
    logic [2:0]             rr_ptr, rr_ptr_nx;
    logic [3:0]             gap_cnt, gap_cnt_nx;
    logic [15:0]            wdog_cnt, wdog_cnt_nx;
    logic [N_PORTS-1:0]     grant_nx;
    logic [2:0]             cur_port_nx;
    logic [DATA_WIDTH-1:0]  data_nx;
    logic                   data_wr_nx;
    logic                   timeout_nx;
    logic                   end_pkt;

    // View of the granted source. The grant is zero outside WAIT_HEAD/XFER,
    // so sel_wr is the "granted write" qualifier everywhere.
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_wr;
    logic                   sel_req;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // can leave it unassigned and infer a latch.
        sel_data = '0;
        sel_wr   = 1'b0;
        sel_req  = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (ov_grant[p]) begin
                sel_data = iv_data[p*DATA_WIDTH +: DATA_WIDTH];
                sel_wr   = iv_data_wr[p];
                sel_req  = iv_req[p];
            end
        end
    end

    // Round-robin pick: first requester at rr_ptr+1, rr_ptr+2, ... wrapping,
    // so the last served port is considered last.
    logic       arb_found;
    logic [2:0] arb_port;

    always_comb begin
        arb_found = 1'b0;
        arb_port  = rr_ptr;
        for (int i = 1; i <= N_PORTS; i++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (!arb_found && iv_req[p] && p == (int'(rr_ptr) + i) % N_PORTS) begin
                    arb_found = 1'b1;
                    arb_port  = 3'(p);
                end
            end
        end
    end

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        gap_cnt_nx  = gap_cnt;
        wdog_cnt_nx = wdog_cnt;
        grant_nx    = ov_grant;
        cur_port_nx = ov_cur_port;
        data_nx     = ov_data;
        data_wr_nx  = 1'b0;
        timeout_nx  = 1'b0;
        end_pkt     = 1'b0;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        grant_nx[p] = (3'(p) == arb_port);
                    end
                    cur_port_nx = arb_port;
                    wdog_cnt_nx = '0;
                    state_nx    = WAIT_HEAD;
                end
            end

            WAIT_HEAD: begin
                if (sel_wr && sel_data[FLAG]) begin
                    data_nx     = sel_data;
                    data_wr_nx  = 1'b1;
                    wdog_cnt_nx = '0;
                    state_nx    = XFER;
                end else if (!sel_req) begin
                    // Withdrawal: no gap, pointer untouched.
                    grant_nx = '0;
                    state_nx = IDLE;
                end else if (sel_wr) begin
                    wdog_cnt_nx = '0;           // pre-head junk, dropped
                end else if (wdog_cnt == WDOG_LAST) begin
                    timeout_nx = 1'b1;
                    end_pkt    = 1'b1;
                end else begin
                    wdog_cnt_nx = wdog_cnt + 16'd1;
                end
            end

            XFER: begin
                if (sel_wr) begin
                    data_nx     = sel_data;
                    data_wr_nx  = 1'b1;
                    wdog_cnt_nx = '0;
                    end_pkt     = sel_data[FLAG];
                end else if (wdog_cnt == WDOG_LAST) begin
                    // Injected tail closes the frame for the downstream parser.
                    data_nx       = '0;
                    data_nx[FLAG] = 1'b1;
                    data_wr_nx    = 1'b1;
                    timeout_nx    = 1'b1;
                    end_pkt       = 1'b1;
                end else begin
                    wdog_cnt_nx = wdog_cnt + 16'd1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 4'd1;
                end
            end

            default: state_nx = IDLE;
        endcase

        if (end_pkt) begin
            grant_nx   = '0;
            rr_ptr_nx  = ov_cur_port;
            gap_cnt_nx = '0;
            state_nx   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gap_cnt     <= '0;
            wdog_cnt    <= '0;
            ov_grant    <= '0;
            ov_cur_port <= '0;
            ov_data     <= '0;
            o_data_wr   <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state       <= state_nx;
            rr_ptr      <= rr_ptr_nx;
            gap_cnt     <= gap_cnt_nx;
            wdog_cnt    <= wdog_cnt_nx;
            ov_grant    <= grant_nx;
            ov_cur_port <= cur_port_nx;
            ov_data     <= data_nx;
            o_data_wr   <= data_wr_nx;
            o_timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_tsmp_pkt_arb.sv
// -----------------------------------------------------------------------------
// tb_tsmp_pkt_arb
//   Directed and randomized checks of tsmp_pkt_arb (N_PORTS=4, GAP_CYCLES=2,
//   TIMEOUT=8). Inputs are driven and outputs sampled on the falling edge.
//   The reference model works on packets: each port owns a list of packets,
//   the next grantee is the first port with packets left after the last one
//   served, and the merged stream is the granted packets' head..tail words.
// -----------------------------------------------------------------------------
module tb_tsmp_pkt_arb;

    localparam int DW  = 9;
    localparam int NP  = 4;
    localparam int GAP = 2;
    localparam int TO  = 8;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP-1:0]     grant;
    logic [NP*DW-1:0]  data;
    logic [NP-1:0]     data_wr;
    logic [DW-1:0]     out_data;
    logic              out_wr;
    logic [2:0]        cur_port;
    logic              timeout;

    tsmp_pkt_arb #(
        .DATA_WIDTH (DW),
        .N_PORTS    (NP),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .iv_req      (req),
        .ov_grant    (grant),
        .iv_data     (data),
        .iv_data_wr  (data_wr),
        .ov_data     (out_data),
        .o_data_wr   (out_wr),
        .ov_cur_port (cur_port),
        .o_timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Timeout pulses seen so far; tests compare against a snapshot.
    int to_pulses = 0;
    always @(posedge clk) if (timeout === 1'b1) to_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    logic [DW-1:0] src_q [NP][$];     // words each source will write
    logic [DW-1:0] fwd_q [NP][$];     // words that must reach the output
    int            plen_q[NP][$];     // forwarded length of each packet
    int            cur_len[NP];
    int            pkts_left[NP];
    int            stall_left[NP];
    int            model_last;
    int            max_stall;
    bit            noise;
    logic [DW-1:0] exp_stream[$];
    int            grant_log[$];

    task automatic add_word(input int p, input logic [DW-1:0] w, input bit fwd);
        src_q[p].push_back(w);
        if (fwd) begin
            fwd_q[p].push_back(w);
            cur_len[p]++;
        end
    endtask

    task automatic end_pkt(input int p);
        plen_q[p].push_back(cur_len[p]);
        cur_len[p] = 0;
        pkts_left[p]++;
    endtask

    task automatic gen_pkt(input int p, input int njunk, input int nwords);
        for (int j = 0; j < njunk; j++) add_word(p, {1'b0, 8'($urandom)}, 1'b0);
        add_word(p, {1'b1, 8'($urandom)}, 1'b1);
        for (int j = 0; j < nwords - 2; j++) add_word(p, {1'b0, 8'($urandom)}, 1'b1);
        add_word(p, {1'b1, 8'($urandom)}, 1'b1);
        end_pkt(p);
    endtask

    function automatic int model_next();
        for (int i = 1; i <= NP; i++) begin
            if (pkts_left[(model_last + i) % NP] > 0) return (model_last + i) % NP;
        end
        return -1;
    endfunction

    // Reactive sources plus monitor. Called and returns on a falling edge.
    task automatic run_auto(input int budget);
        int            cyc;
        int            zero_run;
        int            exp_p;
        int            n;
        int            auto_to;
        bit            seen_grant;
        bit            done;
        logic [NP-1:0] prev_grant;
        logic [NP-1:0] eg;
        cyc = 0; zero_run = 0; auto_to = 0; seen_grant = 0; done = 0;
        prev_grant = grant;
        for (int p = 0; p < NP; p++) stall_left[p] = $urandom_range(0, max_stall);
        while (!done) begin
            data_wr = '0;
            for (int p = 0; p < NP; p++) begin
                if (noise && !grant[p]) begin
                    data[p*DW +: DW] = 9'($urandom);
                    data_wr[p]       = 1'($urandom_range(0, 1));
                end
                if (grant[p] && src_q[p].size() > 0) begin
                    if (stall_left[p] > 0) begin
                        stall_left[p]--;
                    end else begin
                        data[p*DW +: DW] = src_q[p].pop_front();
                        data_wr[p]       = 1'b1;
                        stall_left[p]    = $urandom_range(0, max_stall);
                    end
                end
                req[p] = (src_q[p].size() > 0);
            end
            @(negedge clk);
            cyc++;
            if (timeout === 1'b1) auto_to++;
            if (grant != '0 && prev_grant == '0) begin
                exp_p = model_next();
                eg    = '0;
                if (exp_p >= 0) eg[exp_p] = 1'b1;
                check("rr_grant", grant, eg);
                check("rr_cur_port", cur_port, exp_p);
                if (seen_grant) check("gap_len", zero_run, GAP + 1);
                grant_log.push_back(exp_p);
                if (exp_p >= 0) begin
                    n = plen_q[exp_p].pop_front();
                    repeat (n) exp_stream.push_back(fwd_q[exp_p].pop_front());
                    pkts_left[exp_p]--;
                    model_last = exp_p;
                end
                seen_grant = 1;
                zero_run   = 0;
            end else if (grant == '0) begin
                zero_run++;
            end
            if (out_wr === 1'b1) begin
                if (exp_stream.size() == 0) check("stream_extra", out_data, 9'h000);
                else                        check("stream_word", out_data, exp_stream.pop_front());
            end
            prev_grant = grant;
            done = (exp_stream.size() == 0) && (grant == '0);
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() > 0 || pkts_left[p] > 0) done = 0;
            end
            if (!done && cyc >= budget) begin
                check("auto_budget", cyc, 0);
                done = 1;
            end
        end
        check("auto_no_timeout", auto_to, 0);
        req = '0; data_wr = '0;
    endtask

    task automatic drive_word(input int p, input logic [DW-1:0] w);
        data_wr          = '0;
        data[p*DW +: DW] = w;
        data_wr[p]       = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; data_wr = '0; data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    logic [DW-1:0] sp_words[5] = '{9'h1A5, 9'h0FF, 9'h001, 9'h033, 9'h1C3};
    int            rr_exp[6]   = '{0, 1, 3, 0, 1, 3};

    initial begin
        int n;
        int to_base;
        rst = 1'b1; req = '0; data = '0; data_wr = '0;
        max_stall = 0; noise = 0; model_last = 0;
        for (int p = 0; p < NP; p++) begin
            cur_len[p] = 0; pkts_left[p] = 0; stall_left[p] = 0;
        end

        // ---- reset state ----
        #1;
        check("rst_grant", grant, 0);
        check("rst_data", out_data, 0);
        check("rst_wr", out_wr, 0);
        check("rst_cur_port", cur_port, 0);
        check("rst_timeout", timeout, 0);

        // ---- single port, port 2 ----
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        check("sp_grant", grant, 4'b0100);
        check("sp_cur_port", cur_port, 2);
        for (int i = 0; i < 5; i++) begin
            drive_word(2, sp_words[i]);
            if (i == 4) req = '0;
            @(negedge clk);
            check("sp_wr", out_wr, 1);
            check("sp_data", out_data, sp_words[i]);
            check("sp_grant_hold", grant, (i < 4) ? 4'b0100 : 4'b0000);
        end
        data_wr = '0;
        req     = 4'b0100;    // sole requester: re-granted after the gap
        n = 0;
        while (grant == '0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        // GAP_CYCLES forced cycles plus the IDLE arbitration cycle.
        check("sp_gap_len", n, GAP + 1);
        check("sp_regrant", grant, 4'b0100);
        check("sp_idle_wr", out_wr, 0);
        check("sp_data_hold", out_data, 9'h1C3);

        // ---- round robin ----
        do_reset();
        gen_pkt(3, 0, 3);     // serve port 3 first so the pointer sits at 3
        run_auto(200);
        grant_log.delete();
        for (int k = 0; k < 2; k++) begin
            gen_pkt(0, 0, 3);
            gen_pkt(1, 0, 3);
            gen_pkt(3, 0, 3);
        end
        run_auto(400);
        check("rr_order_len", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check("rr_order", grant_log[i], rr_exp[i]);
        end

        // ---- pre-head junk ----
        add_word(2, 9'h055, 1'b0);
        add_word(2, 9'h066, 1'b0);
        add_word(2, 9'h101, 1'b1);
        add_word(2, 9'h002, 1'b1);
        add_word(2, 9'h1FF, 1'b1);
        end_pkt(2);
        run_auto(200);

        // ---- randomized traffic ----
        max_stall = 3;
        noise     = 1;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) gen_pkt(p, $urandom_range(0, 2), $urandom_range(2, 6));
            end
            run_auto(3000);
        end
        max_stall = 0;
        noise     = 0;

        // ---- mid-packet stall ----
        do_reset();
        to_base = to_pulses;
        req = 4'b0110;
        @(negedge clk);
        check("st_grant", grant, 4'b0010);
        drive_word(1, 9'h180);
        @(negedge clk);
        check("st_head", out_data, 9'h180);
        data_wr = '0;
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("st_delay", n, TO);
        check("st_inj_wr", out_wr, 1);
        check("st_inj_data", out_data, 9'h100);
        check("st_grant_clr", grant, 0);
        @(negedge clk);
        check("st_pulse_end", timeout, 0);
        check("st_wr_end", out_wr, 0);
        n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("st_next_grant", grant, 4'b0100);
        check("st_next_cur", cur_port, 2);
        check("st_one_pulse", to_pulses - to_base, 1);

        // Tail on the cycle the watchdog would expire counts as the tail.
        drive_word(2, 9'h1F0);
        @(negedge clk);
        data_wr = '0;
        repeat (TO - 1) @(negedge clk);
        drive_word(2, 9'h1E1);
        req = '0;
        @(negedge clk);
        data_wr = '0;
        check("tw_tail_data", out_data, 9'h1E1);
        check("tw_tail_wr", out_wr, 1);
        check("tw_no_timeout", timeout, 0);
        check("tw_grant_clr", grant, 0);
        repeat (4) @(negedge clk);
        check("tw_pulses", to_pulses - to_base, 1);

        // ---- request withdrawal ----
        do_reset();
        to_base = to_pulses;
        req = 4'b0001;
        @(negedge clk);
        check("wd_grant", grant, 4'b0001);
        req = '0;
        @(negedge clk);
        check("wd_release", grant, 0);
        req = 4'b0001;
        @(negedge clk);
        check("wd_regrant", grant, 4'b0001);
        check("wd_cur_port", cur_port, 0);
        req = '0;
        repeat (12) @(negedge clk);
        check("wd_grant_idle", grant, 0);
        check("wd_no_timeout", to_pulses - to_base, 0);

        // ---- reset mid-XFER ----
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        check("rx_grant", grant, 4'b0001);
        drive_word(0, 9'h1AA);
        @(negedge clk);
        drive_word(0, 9'h011);
        @(negedge clk);
        check("rx_second", out_data, 9'h011);
        drive_word(0, 9'h022);
        #1 rst = 1'b1;
        #1;
        check("rx_rst_grant", grant, 0);
        check("rx_rst_wr", out_wr, 0);
        check("rx_rst_data", out_data, 0);
        @(negedge clk);
        data_wr = '0;
        rst     = 1'b0;
        @(negedge clk);
        check("rx_after_grant", grant, 4'b0001);
        check("rx_after_cur", cur_port, 0);
        check("rx_no_inject", out_wr, 0);
        check("rx_data_zero", out_data, 0);
        req = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
